// File: rtl/sys_pkg.sv
// -----------------------------------------------------------------------------
// sys_pkg
// Shared definitions for the DRAM arbiter: default bus widths, the starvation
// counter width and the read-response tag that steers one-cycle-late read data
// back to the CPU or DMA.
// -----------------------------------------------------------------------------
package sys_pkg;

  localparam int AW_DEF         = 24;  // requester address width
  localparam int DW_DEF         = 32;  // data width
  localparam int RAM_AW_DEF     = 13;  // RAM address width
  localparam int STARVE_MAX_DEF = 4;   // DMA wait limit in cycles
  localparam int STARVE_W       = 4;   // starvation counter width (limit 1..15)

  // Which requester issued a read.
  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DMA = 1'b1
  } src_e;

  // Which target serves a read.
  typedef enum logic {
    REG_RAM  = 1'b0,
    REG_GPIO = 1'b1
  } region_e;

  // Captured at the cycle a read is taken; steers the response one cycle later.
  typedef struct packed {
    src_e    src;
    region_e region;
    logic    valid;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{src: SRC_CPU, region: REG_RAM, valid: 1'b0};

endpackage

// File: rtl/dram_arb_grant.sv
// -----------------------------------------------------------------------------
// dram_arb_grant
// Combinational RAM grant between CPU and DMA with DMA starvation protection.
// The CPU wins by default; once the DMA has waited STARVE_MAX cycles it takes
// the RAM for one cycle and the CPU is stalled.
//
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_cpu_req        CPU requests the RAM this cycle (GPIO accesses excluded)
//   i_dma_req        DMA requests the RAM this cycle
//   o_cpu_win        CPU drives the RAM this cycle
//   o_dma_win        DMA drives the RAM this cycle
//   o_cpu_stall      CPU RAM request not taken this cycle
// -----------------------------------------------------------------------------
module dram_arb_grant
  import sys_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  output logic o_cpu_win,
  output logic o_dma_win,
  output logic o_cpu_stall
);

  localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_MAX[STARVE_W-1:0];

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_force_dma;
  logic                w_dma_win;
  logic                w_cpu_win;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch can be inferred.
  always_comb begin
    w_force_dma = i_dma_req && (r_starve_cnt == C_STARVE_MAX);
    w_dma_win   = i_dma_req && (!i_cpu_req || w_force_dma);
    w_cpu_win   = i_cpu_req && !w_force_dma;
  end

  // Grants are gated by reset so the RAM is deselected while reset is high,
  // independent of the requests still being presented.
  assign o_dma_win   = !i_rst && w_dma_win;
  assign o_cpu_win   = !i_rst && w_cpu_win;
  assign o_cpu_stall = !i_rst && i_cpu_req && !w_cpu_win;

  // The counter clears on every DMA grant, so a forced DMA win lasts exactly
  // one cycle and the stalled CPU gets the next one.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (!i_dma_req || w_dma_win) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != C_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Shares a single-port synchronous RAM between a CPU and a DMA engine, and
// passes CPU accesses with address bit AW-1 set straight to a GPIO block.
// Read data returns one cycle after the access is taken.
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_cpu_rd/i_cpu_wr             CPU strobes (write wins if both high)
//   i_cpu_addr/i_cpu_din          CPU address (bit AW-1 = GPIO) and write data
//   o_cpu_dout                    CPU read data, valid the cycle after a read
//   o_cpu_stall                   CPU access not taken this cycle; hold strobes
//   i_dma_req/i_dma_we            DMA request and write flag
//   i_dma_addr/i_dma_din          DMA address (RAM only) and write data
//   o_dma_gnt                     DMA drives the RAM this cycle
//   o_dma_rvalid/o_dma_dout       DMA read data, one cycle after a granted read
//   o_ram_*/i_ram_dout            RAM port (o_ram_cs_b active low)
//   o_gpio_*/i_gpio_dout          GPIO port
// -----------------------------------------------------------------------------
module dram_arbiter
  import sys_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RAM_AW     = RAM_AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // CPU
  input  logic              i_cpu_rd,
  input  logic              i_cpu_wr,
  input  logic [AW-1:0]     i_cpu_addr,
  input  logic [DW-1:0]     i_cpu_din,
  output logic [DW-1:0]     o_cpu_dout,
  output logic              o_cpu_stall,
  // DMA
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [AW-1:0]     i_dma_addr,
  input  logic [DW-1:0]     i_dma_din,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DW-1:0]     o_dma_dout,
  // RAM
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [DW-1:0]     o_ram_din,
  output logic              o_ram_rnw,
  output logic              o_ram_cs_b,
  input  logic [DW-1:0]     i_ram_dout,
  // GPIO
  output logic [2:0]        o_gpio_addr,
  output logic [DW-1:0]     o_gpio_din,
  output logic              o_gpio_wr_en,
  input  logic [DW-1:0]     i_gpio_dout
);

  logic    w_cpu_req;
  logic    w_cpu_gpio;
  logic    w_cpu_ram_req;
  logic    w_cpu_win;
  logic    w_dma_win;
  logic    w_cpu_stall;
  rd_tag_t w_cpu_tag_nxt;
  rd_tag_t w_dma_tag_nxt;
  rd_tag_t r_cpu_tag;
  rd_tag_t r_dma_tag;

  // Address bits that neither the RAM nor the GPIO decode.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, i_cpu_addr[AW-2:RAM_AW], i_dma_addr[AW-1:RAM_AW]};

  assign w_cpu_req     = i_cpu_rd || i_cpu_wr;
  assign w_cpu_gpio    = i_cpu_addr[AW-1];
  assign w_cpu_ram_req = w_cpu_req && !w_cpu_gpio;

  dram_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cpu_req   (w_cpu_ram_req),
    .i_dma_req   (i_dma_req),
    .o_cpu_win   (w_cpu_win),
    .o_dma_win   (w_dma_win),
    .o_cpu_stall (w_cpu_stall)
  );

  assign o_cpu_stall = w_cpu_stall;
  assign o_dma_gnt   = w_dma_win;

  // RAM port: the winner of this cycle drives it; idle is deselected, read.
  always_comb begin
    o_ram_addr = '0;
    o_ram_din  = '0;
    o_ram_rnw  = 1'b1;
    o_ram_cs_b = 1'b1;
    if (w_cpu_win) begin
      o_ram_addr = i_cpu_addr[RAM_AW-1:0];
      o_ram_din  = i_cpu_din;
      o_ram_rnw  = !i_cpu_wr;
      o_ram_cs_b = 1'b0;
    end else if (w_dma_win) begin
      o_ram_addr = i_dma_addr[RAM_AW-1:0];
      o_ram_din  = i_dma_din;
      o_ram_rnw  = !i_dma_we;
      o_ram_cs_b = 1'b0;
    end
  end

  // GPIO port bypasses arbitration entirely.
  assign o_gpio_addr  = i_cpu_addr[2:0];
  assign o_gpio_din   = i_cpu_din;
  assign o_gpio_wr_en = !i_rst && w_cpu_gpio && i_cpu_wr;

  // A CPU GPIO read and a DMA RAM read can be taken in the same cycle, so each
  // requester has its own tag; the CPU tag also records which target answers.
  always_comb begin
    w_cpu_tag_nxt        = TAG_IDLE;
    w_cpu_tag_nxt.src    = SRC_CPU;
    w_cpu_tag_nxt.region = w_cpu_gpio ? REG_GPIO : REG_RAM;
    w_cpu_tag_nxt.valid  = !i_rst && i_cpu_rd && !i_cpu_wr && (w_cpu_gpio || w_cpu_win);

    w_dma_tag_nxt        = TAG_IDLE;
    w_dma_tag_nxt.src    = SRC_DMA;
    w_dma_tag_nxt.region = REG_RAM;
    w_dma_tag_nxt.valid  = w_dma_win && !i_dma_we;
  end

  // Clearing the tags on reset drops any read in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cpu_tag <= TAG_IDLE;
      r_dma_tag <= TAG_IDLE;
    end else begin
      r_cpu_tag <= w_cpu_tag_nxt;
      r_dma_tag <= w_dma_tag_nxt;
    end
  end

  assign o_cpu_dout   = (r_cpu_tag.valid && r_cpu_tag.src == SRC_CPU &&
                         r_cpu_tag.region == REG_GPIO) ? i_gpio_dout : i_ram_dout;
  assign o_dma_rvalid = r_dma_tag.valid && (r_dma_tag.src == SRC_DMA) &&
                        (r_dma_tag.region == REG_RAM);
  assign o_dma_dout   = i_ram_dout;

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
// Self-checking bench for dram_arbiter with behavioural RAM and GPIO models.
// Read expectations are queued with the cycle they are due and compared when
// the response appears.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

  localparam int AW     = 24;
  localparam int DW     = 32;
  localparam int RAM_AW = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_cpu_rd, i_cpu_wr;
  logic [AW-1:0]     i_cpu_addr;
  logic [DW-1:0]     i_cpu_din;
  logic [DW-1:0]     o_cpu_dout;
  logic              o_cpu_stall;
  logic              i_dma_req, i_dma_we;
  logic [AW-1:0]     i_dma_addr;
  logic [DW-1:0]     i_dma_din;
  logic              o_dma_gnt, o_dma_rvalid;
  logic [DW-1:0]     o_dma_dout;
  logic [RAM_AW-1:0] o_ram_addr;
  logic [DW-1:0]     o_ram_din;
  logic              o_ram_rnw, o_ram_cs_b;
  logic [DW-1:0]     ram_dout;
  logic [2:0]        o_gpio_addr;
  logic [DW-1:0]     o_gpio_din;
  logic              o_gpio_wr_en;
  logic [DW-1:0]     gpio_dout;

  always #5 clk = ~clk;

  dram_arbiter #(
    .AW(AW), .DW(DW), .RAM_AW(RAM_AW), .STARVE_MAX(4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_rd     (i_cpu_rd),
    .i_cpu_wr     (i_cpu_wr),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_din    (i_cpu_din),
    .o_cpu_dout   (o_cpu_dout),
    .o_cpu_stall  (o_cpu_stall),
    .i_dma_req    (i_dma_req),
    .i_dma_we     (i_dma_we),
    .i_dma_addr   (i_dma_addr),
    .i_dma_din    (i_dma_din),
    .o_dma_gnt    (o_dma_gnt),
    .o_dma_rvalid (o_dma_rvalid),
    .o_dma_dout   (o_dma_dout),
    .o_ram_addr   (o_ram_addr),
    .o_ram_din    (o_ram_din),
    .o_ram_rnw    (o_ram_rnw),
    .o_ram_cs_b   (o_ram_cs_b),
    .i_ram_dout   (ram_dout),
    .o_gpio_addr  (o_gpio_addr),
    .o_gpio_din   (o_gpio_din),
    .o_gpio_wr_en (o_gpio_wr_en),
    .i_gpio_dout  (gpio_dout)
  );

  // Behavioural devices: synchronous RAM and GPIO register file, both with a
  // one-cycle read.
  logic [DW-1:0] ram_mem   [0:(1<<RAM_AW)-1];
  logic [DW-1:0] gpio_regs [0:7];

  always @(posedge clk) begin
    if (!o_ram_cs_b) begin
      if (!o_ram_rnw) ram_mem[o_ram_addr] <= o_ram_din;
      else            ram_dout <= ram_mem[o_ram_addr];
    end
    if (o_gpio_wr_en) gpio_regs[o_gpio_addr] <= o_gpio_din;
    gpio_dout <= gpio_regs[o_gpio_addr];
  end

  // Reference contents and scoreboard.
  logic [DW-1:0] ref_mem  [0:(1<<RAM_AW)-1];
  logic [DW-1:0] ref_gpio [0:7];

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  int          n_cmp   = 0;
  int          n_err   = 0;
  int unsigned cyc_cnt = 0;
  bit          mon_en  = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc_cnt);
    end
  endtask

  // One cycle of stimulus with the expected grant/stall for that cycle.
  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic dreq, input logic dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input logic exp_gnt, input logic exp_stall);
    logic cpu_ram;
    exp_t e;
    @(negedge clk);
    i_cpu_rd = rd;   i_cpu_wr = wr;  i_cpu_addr = ca; i_cpu_din = cd;
    i_dma_req = dreq; i_dma_we = dwe; i_dma_addr = da; i_dma_din = dd;
    #1;
    check("dma_gnt", o_dma_gnt, exp_gnt);
    check("cpu_stall", o_cpu_stall, exp_stall);
    check("gpio_wr_en", o_gpio_wr_en, wr & ca[AW-1]);
    cpu_ram = (rd | wr) & !ca[AW-1] & !exp_stall;
    check("ram_cs_b", o_ram_cs_b, !(cpu_ram | exp_gnt));
    if (cpu_ram) begin
      check("ram_addr_cpu", o_ram_addr, ca[RAM_AW-1:0]);
      check("ram_rnw_cpu", o_ram_rnw, !wr);
      check("ram_din_cpu", o_ram_din, cd);
    end else if (exp_gnt) begin
      check("ram_addr_dma", o_ram_addr, da[RAM_AW-1:0]);
      check("ram_rnw_dma", o_ram_rnw, !dwe);
      check("ram_din_dma", o_ram_din, dd);
    end else begin
      check("ram_rnw_idle", o_ram_rnw, 1'b1);
    end
    if (ca[AW-1] && (rd || wr)) begin
      check("gpio_addr", o_gpio_addr, ca[2:0]);
      if (wr) check("gpio_din", o_gpio_din, cd);
    end
    e.due = cyc_cnt + 1;
    if ((rd || wr) && !exp_stall) begin
      if (wr) begin
        if (ca[AW-1]) ref_gpio[ca[2:0]] = cd;
        else          ref_mem[ca[RAM_AW-1:0]] = cd;
      end else begin
        e.data = ca[AW-1] ? ref_gpio[ca[2:0]] : ref_mem[ca[RAM_AW-1:0]];
        cpu_q.push_back(e);
      end
    end
    if (exp_gnt) begin
      if (dwe) ref_mem[da[RAM_AW-1:0]] = dd;
      else begin
        e.data = ref_mem[da[RAM_AW-1:0]];
        dma_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  // Response monitor: rvalid must be high exactly when a DMA read is due.
  always @(negedge clk) begin
    exp_t e;
    logic exp_rv;
    #2;
    if (mon_en && !rst) begin
      exp_rv = (dma_q.size() > 0) && (dma_q[0].due == cyc_cnt);
      check("dma_rvalid", o_dma_rvalid, exp_rv);
      if (exp_rv) begin
        e = dma_q.pop_front();
        check("dma_dout", o_dma_dout, e.data);
      end
      if ((cpu_q.size() > 0) && (cpu_q[0].due == cyc_cnt)) begin
        e = cpu_q.pop_front();
        check("cpu_dout", o_cpu_dout, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int            k;
    bit            force_dma;

    for (int i = 0; i < (1 << RAM_AW); i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      gpio_regs[i] = '0;
      ref_gpio[i]  = '0;
    end
    ram_dout  = '0;
    gpio_dout = '0;

    // Reset with active requests presented: every output must stay idle.
    rst = 1'b1;
    i_cpu_rd = 1'b0; i_cpu_wr = 1'b1; i_cpu_addr = 24'h800001; i_cpu_din = 32'h1;
    i_dma_req = 1'b1; i_dma_we = 1'b0; i_dma_addr = 24'h000010; i_dma_din = '0;
    #12;
    check("rst_gnt", o_dma_gnt, 1'b0);
    check("rst_stall", o_cpu_stall, 1'b0);
    check("rst_cs_b", o_ram_cs_b, 1'b1);
    check("rst_rnw", o_ram_rnw, 1'b1);
    check("rst_gpio_wr_en", o_gpio_wr_en, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", o_dma_rvalid, 1'b0);
    @(negedge clk);
    i_cpu_rd = 1'b0; i_cpu_wr = 1'b0; i_dma_req = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // CPU write then read back.
    drive(0, 1, 24'h001234, 32'hDEADBEEF, 0, 0, '0, '0, 0, 0);
    drive(1, 0, 24'h001234, '0,           0, 0, '0, '0, 0, 0);
    idle(1);

    // DMA-only writes, then back-to-back reads (bit AW-1 of the address ignored).
    drive(0, 0, '0, '0, 1, 1, 24'h000010, 32'hA5A50010, 1, 0);
    drive(0, 0, '0, '0, 1, 1, 24'h000011, 32'h5A5A0011, 1, 0);
    drive(0, 0, '0, '0, 1, 0, 24'h000010, '0,           1, 0);
    drive(0, 0, '0, '0, 1, 0, 24'h800011, '0,           1, 0);
    idle(2);

    // Preload RAM through the CPU.
    for (int i = 0; i < 5; i++) begin
      a = 24'h000100 + 24'(i);
      drive(0, 1, a, 32'hC0000000 + 32'(i), 0, 0, '0, '0, 0, 0);
    end

    // Alternating sources with no bubble, then a plain conflict (CPU wins).
    drive(1, 0, 24'h000100, '0, 0, 0, '0,         '0, 0, 0);
    drive(0, 0, '0,         '0, 1, 0, 24'h000010, '0, 1, 0);
    drive(1, 0, 24'h000101, '0, 0, 0, '0,         '0, 0, 0);
    drive(0, 0, '0,         '0, 1, 0, 24'h000011, '0, 1, 0);
    drive(1, 0, 24'h000102, '0, 1, 0, 24'h000010, '0, 0, 0);
    drive(0, 0, '0,         '0, 1, 0, 24'h000010, '0, 1, 0);
    idle(2);

    // Both strobes high: write wins, nothing is read.
    drive(1, 1, 24'h001300, 32'h13000013, 0, 0, '0, '0, 0, 0);
    drive(1, 0, 24'h001300, '0,           0, 0, '0, '0, 0, 0);
    idle(1);

    // Starvation: CPU reads every cycle, DMA always requesting; DMA forced in
    // every fifth cycle and the stalled CPU read is retried unchanged.
    k = 0;
    for (int i = 0; i < 15; i++) begin
      force_dma = ((i % 5) == 4);
      a = 24'h000100 + 24'(k);
      drive(1, 0, a, '0, 1, 0, 24'h000010, '0, force_dma, force_dma);
      if (!force_dma) k = (k + 1) % 5;
    end
    idle(2);

    // GPIO write in parallel with a DMA RAM write, then parallel reads.
    drive(0, 1, 24'h800002, 32'h00000005, 1, 1, 24'h000020, 32'h20202020, 1, 0);
    drive(1, 0, 24'h800002, '0,           1, 0, 24'h000020, '0,           1, 0);
    drive(0, 1, 24'h800007, 32'h77770007, 0, 0, '0,         '0,           0, 0);
    drive(1, 0, 24'h800007, '0,           1, 0, 24'h001234, '0,           1, 0);
    idle(2);

    // Reset while a DMA read is in flight: response dropped.
    drive(0, 0, '0, '0, 1, 0, 24'h000011, '0, 1, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    cpu_q.delete();
    dma_q.delete();
    #1;
    check("mid_rst_rvalid", o_dma_rvalid, 1'b0);
    check("mid_rst_gnt", o_dma_gnt, 1'b0);
    check("mid_rst_cs_b", o_ram_cs_b, 1'b1);
    check("mid_rst_rnw", o_ram_rnw, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_cpu_rd = 1'b0; i_cpu_wr = 1'b0; i_dma_req = 1'b0;
    rst = 1'b0;
    idle(3);

    // Starvation counter restarted from zero: DMA forced on the fifth cycle.
    for (int i = 0; i < 5; i++) begin
      force_dma = (i == 4);
      a = 24'h000100 + 24'(i);
      drive(1, 0, a, '0, 1, 0, 24'h000010, '0, force_dma, force_dma);
    end
    idle(3);

    check("scoreboard_drained", 32'(cpu_q.size() + dma_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
